// File: rtl/regfile_pkg.sv
// Shared widths and bus types for the 32x32 register file and its decoder/mux helpers.
// All buses are big-endian indexed: element [0] is the MSB.
package regfile_pkg;

  localparam int unsigned RF_WIDTH  = 32;
  localparam int unsigned RF_NREGS  = 32;
  localparam int unsigned RF_ADDR_W = 5;

  typedef logic [0:RF_ADDR_W-1] rf_addr_t;
  typedef logic [0:RF_WIDTH-1]  rf_word_t;

  localparam rf_addr_t RF_ZERO_ADDR = '0;

endpackage

// File: rtl/decoder5to32_we.sv
// Write-address decoder: one-hot register enable gated by we; entry 0 never enabled.
// Built as a 2->4 (address MSBs) by 3->8 (address LSBs) product, mirroring the read mux tree.
module decoder5to32_we
  import regfile_pkg::*;
(
  input  logic                  we,
  input  rf_addr_t              addr,
  output logic [0:RF_NREGS-1]   wen_c
);

  logic [0:3] hi;
  logic [0:7] lo;

  always_comb begin
    hi = '0;
    lo = '0;
    hi[addr[0:1]] = we;
    lo[addr[2:4]] = 1'b1;
  end

  for (genvar i = 0; i < 4; i++) begin : g_hi
    for (genvar j = 0; j < 8; j++) begin : g_lo
      if (i == 0 && j == 0) begin : g_zero
        assign wen_c[0] = 1'b0;
      end else begin : g_sel
        assign wen_c[i*8+j] = hi[i] & lo[j];
      end
    end
  end

endmodule

// File: rtl/mux32to1_word.sv
// 32:1 word-select mux: address LSBs pick within each group of 8, MSBs pick the group.
module mux32to1_word
  import regfile_pkg::*;
(
  input  rf_word_t din [RF_NREGS],
  input  rf_addr_t sel,
  output rf_word_t dout_c
);

  rf_word_t grp [4];

  always_comb begin
    for (int g = 0; g < 4; g++) begin
      grp[g] = din[{2'(g), sel[2:4]}];
    end
    dout_c = grp[sel[0:1]];
  end

endmodule

// File: rtl/regfile_32x32_w1r2.sv
// 32x32 register file, one write port, two combinational read ports, r0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a matching read port.
module regfile_32x32_w1r2
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH  = RF_WIDTH,
  parameter int unsigned NREGS  = RF_NREGS,
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [0:ADDR_W-1] waddr,
  input  logic [0:WIDTH-1]  wdata,
  input  logic [0:ADDR_W-1] raddr_a,
  input  logic [0:ADDR_W-1] raddr_b,
  output logic [0:WIDTH-1]  rdata_a,
  output logic [0:WIDTH-1]  rdata_b
);

  // The decoder and mux tree are fixed at the package geometry.
  if (WIDTH != RF_WIDTH || NREGS != RF_NREGS || ADDR_W != RF_ADDR_W ||
      NREGS != (32'd1 << ADDR_W)) begin : g_cfg_chk
    $error("regfile_32x32_w1r2: unsupported WIDTH/NREGS/ADDR_W");
  end

  logic [0:NREGS-1] wen_c;
  rf_word_t         regs_q   [1:NREGS-1];
  rf_word_t         rd_words [NREGS];
  rf_word_t         mux_a_c;
  rf_word_t         mux_b_c;

  decoder5to32_we u_dec (
    .we    (we),
    .addr  (waddr),
    .wen_c (wen_c)
  );

  // Storage for r1..r31; reset clears asynchronously and wins over any write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < int'(NREGS); i++) begin
        if (wen_c[i]) begin
          regs_q[i] <= wdata;
        end
      end
    end
  end

  always_comb begin
    rd_words[0] = '0;
    for (int i = 1; i < int'(NREGS); i++) begin
      rd_words[i] = regs_q[i];
    end
  end

  mux32to1_word u_mux_a (
    .din    (rd_words),
    .sel    (raddr_a),
    .dout_c (mux_a_c)
  );

  mux32to1_word u_mux_b (
    .din    (rd_words),
    .sel    (raddr_b),
    .dout_c (mux_b_c)
  );

`ifdef REGFILE_BYPASS_EN
  logic fwd_ok_c;

  // Forward the in-flight write to any port reading the same non-zero address.
  always_comb begin
    fwd_ok_c = rst_n && we && (waddr != RF_ZERO_ADDR);
    rdata_a  = mux_a_c;
    rdata_b  = mux_b_c;
    if (fwd_ok_c && (raddr_a == waddr)) begin
      rdata_a = wdata;
    end
    if (fwd_ok_c && (raddr_b == waddr)) begin
      rdata_b = wdata;
    end
  end
`else
  always_comb begin
    rdata_a = mux_a_c;
    rdata_b = mux_b_c;
  end
`endif

endmodule

// File: tb/tb_regfile_32x32_w1r2.sv
// Self-checking bench for regfile_32x32_w1r2: directed cases plus randomized traffic against an array model.
module tb_regfile_32x32_w1r2;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [0:4]  waddr;
  logic [0:31] wdata;
  logic [0:4]  raddr_a;
  logic [0:4]  raddr_b;
  logic [0:31] rdata_a;
  logic [0:31] rdata_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];

  regfile_32x32_w1r2 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Expected read value from the register contents and the current write-port inputs.
  function automatic logic [31:0] exp_rd(input logic [0:4] a);
    if (a == 5'd0) return 32'h0;
    if (!rst_n) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && waddr != 5'd0 && a == waddr) return wdata;
`endif
    return model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic do_write(input logic [0:4] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = d;
    @(posedge clk);
    if (a != 5'd0) model[a] = d;
    #1;
    we = 1'b0;
  endtask

  task automatic read_check(input logic [0:4] a, input logic [0:4] b, input string tag);
    raddr_a = a;
    raddr_b = b;
    #1;
    check($sformatf("%s_a[r%0d]", tag, a), rdata_a, exp_rd(a));
    check($sformatf("%s_b[r%0d]", tag, b), rdata_b, exp_rd(b));
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      read_check(5'(i), 5'(31 - i), tag);
    end
  endtask

  initial begin
    logic [31:0] coll_exp;
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
    clear_model();
    repeat (2) @(negedge clk);
    raddr_a = 5'd5; raddr_b = 5'd31;
    #1;
    check("in_reset_a", rdata_a, 32'h0);
    check("in_reset_b", rdata_b, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset mid-cycle after a write
    do_write(5'd5, 32'hDEADBEEF);
    read_check(5'd5, 5'd5, "pre_reset");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_r5", rdata_a, 32'h0);
    clear_model();
    read_all("reset_all");
    @(negedge clk);
    rst_n = 1'b1;

    do_write(5'd7, 32'h12345678);
    read_check(5'd7, 5'd7, "wr_rd_r7");

    // Zero register is not writable
    do_write(5'd0, 32'hFFFFFFFF);
    read_check(5'd0, 5'd0, "zero_reg");
    read_all("zero_reg_others");

    for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i) * 32'h01010101);
    read_all("walk");

    // Read/write collision on r3
    do_write(5'd3, 32'hAAAA5555);
    @(negedge clk);
    we = 1'b1; waddr = 5'd3; wdata = 32'h0F0F0F0F; raddr_a = 5'd3; raddr_b = 5'd4;
`ifdef REGFILE_BYPASS_EN
    coll_exp = 32'h0F0F0F0F;
`else
    coll_exp = 32'hAAAA5555;
`endif
    #1;
    check("collision_before_edge", rdata_a, coll_exp);
    check("collision_other_port", rdata_b, 32'h04040404);
    @(posedge clk);
    model[3] = 32'h0F0F0F0F;
    #1;
    check("collision_after_edge", rdata_a, 32'h0F0F0F0F);
    we = 1'b0;

    // Reset coinciding with a write drops the write
    @(negedge clk);
    we = 1'b1; waddr = 5'd9; wdata = 32'hCAFEF00D; rst_n = 1'b0;
    clear_model();
    raddr_a = 5'd9;
    #1;
    check("reset_vs_write_during", rdata_a, 32'h0);
    @(posedge clk);
    @(negedge clk);
    we = 1'b0; rst_n = 1'b1;
    read_check(5'd9, 5'd9, "reset_vs_write_r9");
    do_write(5'd9, 32'h13572468);
    read_check(5'd9, 5'd1, "first_write_after_reset");

    // Randomized traffic, including X on wdata while we=0
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      we      = 1'($urandom_range(0, 1));
      waddr   = 5'($urandom);
      wdata   = $urandom;
      raddr_a = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
      raddr_b = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
      if (!we && $urandom_range(0, 3) == 0) wdata = 'x;
      #1;
      check($sformatf("rand%0d_a[r%0d]", n, raddr_a), rdata_a, exp_rd(raddr_a));
      check($sformatf("rand%0d_b[r%0d]", n, raddr_b), rdata_b, exp_rd(raddr_b));
      @(posedge clk);
      if (we && waddr != 5'd0) model[waddr] = wdata;
    end
    @(negedge clk);
    we = 1'b0;
    read_all("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
